// File: rtl/draw_grid_if.sv
// VGA timing and pixel bundle shared between raster-pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_grid.sv
// Overlays a COLS x ROWS cell grid on a VGA stream with a two-stage pipeline.
// Optional tear-free cursor cell highlight is enabled by macro DRAW_GRID_CURSOR_EN.
module draw_grid #(
  parameter int          X0       = 64,
  parameter int          Y0       = 124,
  parameter int          CELL_PX  = 32,
  parameter int          COLS     = 10,
  parameter int          ROWS     = 10,
  parameter logic [11:0] LINE_RGB = 12'h0_0_0,
  parameter logic [11:0] CELL_RGB = 12'h2_4_a,
  parameter logic [11:0] CUR_RGB  = 12'hf_f_0
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          i_vga,
  vga_if.out         o_vga,
  input  logic [3:0] i_cur_col,
  input  logic [3:0] i_cur_row,
  input  logic       i_cur_vld,
  output logic [3:0] o_cell_col,
  output logic [3:0] o_cell_row,
  output logic       o_in_grid
);

  localparam int          PX_W    = (CELL_PX > 2) ? $clog2(CELL_PX) : 1;
  localparam logic [10:0] X0_C    = 11'(X0);
  localparam logic [10:0] Y0_C    = 11'(Y0);
  localparam logic [10:0] XE_C    = 11'(X0 + COLS * CELL_PX);
  localparam logic [10:0] YE_C    = 11'(Y0 + ROWS * CELL_PX);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_PX - 1);
  localparam logic [4:0]  COLS_C  = 5'(COLS);
  localparam logic [4:0]  ROWS_C  = 5'(ROWS);
  localparam logic [4:0]  COL_MAX = 5'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);

  // stage 1
  logic [10:0]     r1_hcount, r1_vcount;
  logic            r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic [11:0]     r1_rgb;
  logic [PX_W-1:0] r_px, r_py;
  logic [4:0]      r_cx, r_cy;

  // stage 2
  logic [10:0]     r2_hcount, r2_vcount;
  logic            r2_hsync, r2_vsync, r2_hblnk, r2_vblnk;
  logic [11:0]     r2_rgb;
  logic [3:0]      r2_cell_col, r2_cell_row;
  logic            r2_in_grid;

  logic            w_h_step, w_v_step, w_line_start;
  logic            w_h_in, w_v_in, w_rect, w_blank, w_line, w_hit;
  logic [11:0]     w_rgb;
  logic [3:0]      w_cell_col, w_cell_row;

  // Counters step only strictly after the loading pixel/line, up to the closing one.
  assign w_h_step     = (i_vga.hcount > X0_C) && (i_vga.hcount <= XE_C);
  assign w_v_step     = (i_vga.vcount > Y0_C) && (i_vga.vcount <= YE_C);
  assign w_line_start = (i_vga.hcount == 11'd0);

  // Stage 1: timing and upstream colour delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_hcount <= 11'd0;
      r1_vcount <= 11'd0;
      r1_hsync  <= 1'b0;
      r1_vsync  <= 1'b0;
      r1_hblnk  <= 1'b0;
      r1_vblnk  <= 1'b0;
      r1_rgb    <= 12'h0_0_0;
    end else begin
      r1_hcount <= i_vga.hcount;
      r1_vcount <= i_vga.vcount;
      r1_hsync  <= i_vga.hsync;
      r1_vsync  <= i_vga.vsync;
      r1_hblnk  <= i_vga.hblnk;
      r1_vblnk  <= i_vga.vblnk;
      r1_rgb    <= i_vga.rgb;
    end
  end

  // Stage 1: horizontal pixel/cell counters; cx saturates at COLS on the closing line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px <= '0;
      r_cx <= 5'd0;
    end else if (i_vga.hcount == X0_C) begin
      r_px <= '0;
      r_cx <= 5'd0;
    end else if (w_h_step) begin
      if (r_px == PX_LAST) begin
        r_px <= '0;
        r_cx <= (r_cx == COLS_C) ? r_cx : r_cx + 5'd1;
      end else begin
        r_px <= r_px + PX_W'(1);
      end
    end else begin
      r_px <= r_px;
      r_cx <= r_cx;
    end
  end

  // Stage 1: vertical counters advance once per line at hcount 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_py <= '0;
      r_cy <= 5'd0;
    end else if (w_line_start && (i_vga.vcount == Y0_C)) begin
      r_py <= '0;
      r_cy <= 5'd0;
    end else if (w_line_start && w_v_step) begin
      if (r_py == PX_LAST) begin
        r_py <= '0;
        r_cy <= (r_cy == ROWS_C) ? r_cy : r_cy + 5'd1;
      end else begin
        r_py <= r_py + PX_W'(1);
      end
    end else begin
      r_py <= r_py;
      r_cy <= r_cy;
    end
  end

`ifdef DRAW_GRID_CURSOR_EN
  logic [3:0] r_cur_col, r_cur_row;
  logic       r_cur_vld;

  // Cursor is latched only at frame origin so a frame never shows two positions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_col <= 4'd0;
      r_cur_row <= 4'd0;
      r_cur_vld <= 1'b0;
    end else if ((i_vga.hcount == 11'd0) && (i_vga.vcount == 11'd0)) begin
      r_cur_col <= i_cur_col;
      r_cur_row <= i_cur_row;
      r_cur_vld <= i_cur_vld;
    end else begin
      r_cur_col <= r_cur_col;
      r_cur_row <= r_cur_row;
      r_cur_vld <= r_cur_vld;
    end
  end

  assign w_hit = r_cur_vld && (r_cx == {1'b0, r_cur_col}) && (r_cy == {1'b0, r_cur_row});
`else
  logic w_cur_unused;
  assign w_cur_unused = ^{i_cur_col, i_cur_row, i_cur_vld};
  assign w_hit        = 1'b0;
`endif

  assign w_h_in     = (r1_hcount >= X0_C) && (r1_hcount <= XE_C);
  assign w_v_in     = (r1_vcount >= Y0_C) && (r1_vcount <= YE_C);
  assign w_rect     = w_h_in && w_v_in;
  assign w_blank    = r1_hblnk || r1_vblnk;
  assign w_line     = (r_px == '0) || (r_py == '0) || (r1_hcount == XE_C) || (r1_vcount == YE_C);
  assign w_cell_col = (r_cx > COL_MAX) ? COL_MAX[3:0] : r_cx[3:0];
  assign w_cell_row = (r_cy > ROW_MAX) ? ROW_MAX[3:0] : r_cy[3:0];

  // Colour precedence: blanking, grid line, cursor, cell fill, pass-through.
  always_comb begin
    w_rgb = r1_rgb;
    if (w_blank) begin
      w_rgb = 12'h0_0_0;
    end else if (w_rect && w_line) begin
      w_rgb = LINE_RGB;
    end else if (w_rect && w_hit) begin
      w_rgb = CUR_RGB;
    end else if (w_rect) begin
      w_rgb = CELL_RGB;
    end else begin
      w_rgb = r1_rgb;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_hcount   <= 11'd0;
      r2_vcount   <= 11'd0;
      r2_hsync    <= 1'b0;
      r2_vsync    <= 1'b0;
      r2_hblnk    <= 1'b0;
      r2_vblnk    <= 1'b0;
      r2_rgb      <= 12'h0_0_0;
      r2_cell_col <= 4'd0;
      r2_cell_row <= 4'd0;
      r2_in_grid  <= 1'b0;
    end else begin
      r2_hcount   <= r1_hcount;
      r2_vcount   <= r1_vcount;
      r2_hsync    <= r1_hsync;
      r2_vsync    <= r1_vsync;
      r2_hblnk    <= r1_hblnk;
      r2_vblnk    <= r1_vblnk;
      r2_rgb      <= w_rgb;
      r2_cell_col <= w_cell_col;
      r2_cell_row <= w_cell_row;
      r2_in_grid  <= w_rect && !w_blank;
    end
  end

  assign o_vga.hcount = r2_hcount;
  assign o_vga.vcount = r2_vcount;
  assign o_vga.hsync  = r2_hsync;
  assign o_vga.vsync  = r2_vsync;
  assign o_vga.hblnk  = r2_hblnk;
  assign o_vga.vblnk  = r2_vblnk;
  assign o_vga.rgb    = r2_rgb;
  assign o_cell_col   = r2_cell_col;
  assign o_cell_row   = r2_cell_row;
  assign o_in_grid    = r2_in_grid;

endmodule

// File: doc/draw_grid.md
DRAW_GRID -- requirements
Module: draw_grid

Interface
REQ-001 Parameter X0, default 64, meaning hcount of the grid's left line.
REQ-002 Parameter Y0, default 124, meaning vcount of the grid's top line.
REQ-003 Parameter CELL_PX, default 32, meaning cell pitch in pixels (>=2), including one line pixel.
REQ-004 Parameter COLS, default 10, meaning number of cell columns (1..16).
REQ-005 Parameter ROWS, default 10, meaning number of cell rows (1..16).
REQ-006 Parameter LINE_RGB, default 12'h0_0_0, meaning grid line colour.
REQ-007 Parameter CELL_RGB, default 12'h2_4_a, meaning cell fill colour.
REQ-008 Parameter CUR_RGB, default 12'hf_f_0, meaning cursor cell fill colour.
REQ-009 clk  in  1  clock.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 in  vga_if.in  -  timing (hcount, vcount, hsync, vsync, hblnk, vblnk) and upstream rgb.
REQ-012 out  vga_if.out  -  delayed timing and composited rgb.
REQ-013 cur_col, cur_row  in  4 each  cursor cell coordinates.
REQ-014 cur_vld  in  1  cursor display enable.
REQ-015 cell_col, cell_row  out  4 each  cell under the current out pixel, valid when in_grid=1.
REQ-016 in_grid  out  1  out pixel lies inside the grid rectangle.

Function
REQ-017 Grid rectangle SHALL be X0 <= hcount <= XE and Y0 <= vcount <= YE, where XE = X0 + COLS*CELL_PX and YE = Y0 + ROWS*CELL_PX.
REQ-018 Cell index SHALL come from incremental counters (px, cx horizontally; py, cy vertically); no divider or modulo on hcount/vcount.
REQ-019 px/cx SHALL load 0 when in.hcount == X0, otherwise, while in.hcount is inside the grid, px SHALL increment, wrap CELL_PX-1 -> 0 and increment cx on the wrap.
REQ-020 py/cy SHALL update once per line, when in.hcount == 0: load 0 on in.vcount == Y0, otherwise, while in.vcount is inside the grid, step with the same wrap rule.
REQ-021 cx/cy SHALL saturate at COLS/ROWS on the closing line, and SHALL never wrap to 0 inside the rectangle.
REQ-022 Pipeline: stage 1 SHALL register timing, in.rgb and the counters, and stage 2 SHALL register out.*; all out signals SHALL lag in by exactly 2 clk cycles.
REQ-023 Pixel colour precedence, highest first:
- blanking (hblnk|vblnk) -> 12'h0_0_0
- inside rectangle and (px==0 | py==0 | hcount==XE | vcount==YE) -> LINE_RGB
- inside rectangle and cursor hit -> CUR_RGB
- inside rectangle -> CELL_RGB
- otherwise -> delayed in.rgb (pass-through)
REQ-024 cell_col/cell_row SHALL be min(cx, COLS-1) / min(cy, ROWS-1), aligned with out.
REQ-025 in_grid SHALL be aligned with out and SHALL be 0 during blanking.

Reset
REQ-026 During rst, all out.* fields, cell_col, cell_row, in_grid, counters and latched cursor SHALL be 0.
REQ-027 Reset mid-frame: the first valid picture SHALL be the first line after the next in.vcount == Y0 line start; out SHALL follow in with 2-cycle latency from the first post-reset cycle.

Configuration
REQ-028 Macro DRAW_GRID_CURSOR_EN defined: cur_col/cur_row/cur_vld SHALL be sampled into registers only when in.hcount==0 and in.vcount==0 (tear-free), and a cursor hit is cx==cur_col_q & cy==cur_row_q & cur_vld_q.
REQ-029 Macro DRAW_GRID_CURSOR_EN undefined: the cursor ports SHALL exist but be ignored, no cursor registers SHALL be inferred, and a cursor hit SHALL never occur.

Verification
REQ-030 Reset: rst high 3 cycles with random in -> all outputs 0. Release rst -> out.hcount equals in.hcount from 2 cycles earlier.
REQ-031 Defaults, pixel (64,124) -> LINE_RGB. Pixel (65,125) -> CELL_RGB with cell (0,0). Pixel (96,156) -> LINE_RGB. Pixel (384,444) -> LINE_RGB (closing corner).
REQ-032 Defaults, pixel (383,443) -> CELL_RGB with cell_col=9, cell_row=9, in_grid=1. Pixel (385,300) -> in.rgb passed through, in_grid=0.
REQ-033 Pixel inside grid with hblnk=1 -> rgb 0, in_grid 0.
REQ-034 With DRAW_GRID_CURSOR_EN, cur=(3,2), cur_vld=1 sampled at frame start -> pixel (170,200) is CUR_RGB. Changing cur mid-frame -> no effect until the next frame.
REQ-035 Without DRAW_GRID_CURSOR_EN, same stimulus -> pixel (170,200) is CELL_RGB.
